// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: parametrised h/v timing, incremental framebuffer addressing,
// optional 2^n pixel replication and read-latency compensation on sync/valid/colour.
module vga_fb_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int RD_LAT      = 0,
  parameter int COLOR_W     = 8,
  parameter int ADDR_W      = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 valid,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int SRC_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam int SRC_H   = V_ACTIVE >> SCALE_SHIFT;

  localparam bit PARAMS_OK =
      (SCALE_SHIFT >= 0) && (SCALE_SHIFT <= 3) &&
      (RD_LAT >= 0) && (RD_LAT <= 4) &&
      (H_ACTIVE > 0) && (V_ACTIVE > 0) && (COLOR_W > 0) &&
      (ADDR_W > 0) && (ADDR_W <= 32) &&
      (H_FP >= 0) && (H_SYNC >= 0) && (H_BP >= 0) &&
      (V_FP >= 0) && (V_SYNC >= 0) && (V_BP >= 0) &&
      ((H_ACTIVE % (1 << SCALE_SHIFT)) == 0) &&
      ((V_ACTIVE % (1 << SCALE_SHIFT)) == 0) &&
      ((longint'(SRC_W) * longint'(SRC_H)) <= (longint'(1) << ADDR_W));

  if (!PARAMS_OK) begin : g_bad_params
    $error("vga_fb_scanout: illegal parameter set");
  end

  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG_L = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END_L = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG_L = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END_L = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] SRC_W_L  = ADDR_W'(SRC_W);

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              h_wrap, v_wrap;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    if (!en) begin
      h_cnt_d     = '0;
      v_cnt_d     = '0;
      line_base_d = '0;
    end else if (h_wrap) begin
      h_cnt_d = '0;
      if (v_wrap) begin
        // Frame wrap wins over any pending source-row advance.
        v_cnt_d     = '0;
        line_base_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
        if ((v_cnt_q < V_ACT_L) && ((v_cnt_q & V_MASK) == V_MASK)) begin
          line_base_d = line_base_q + SRC_W_L;
        end
      end
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
    end
  end

  logic act, hs_reg, vs_reg, first_px;
  logic [HW-1:0] h_src;

  assign act      = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
  assign hs_reg   = (h_cnt_q >= HS_BEG_L) && (h_cnt_q < HS_END_L);
  assign vs_reg   = (v_cnt_q >= VS_BEG_L) && (v_cnt_q < VS_END_L);
  assign first_px = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign h_src    = h_cnt_q >> SCALE_SHIFT;
  assign rd_en    = act && en && !reset;
  assign rd_addr  = line_base_q + ADDR_W'(h_src);

  // Tap bits: {first pixel, vsync region, hsync region, visible}; idle while disabled.
  logic [3:0] tap_in, tap_out;
  assign tap_in = en ? {first_px, vs_reg, hs_reg, act} : 4'b0000;

  if (RD_LAT == 0) begin : g_no_dly
    assign tap_out = tap_in;
  end else begin : g_dly
    logic [3:0] dly_q [RD_LAT];
    logic [3:0] dly_d [RD_LAT];

    always_comb begin
      dly_d[0] = tap_in;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    // NOTE: this short control pipeline is reset (unlike a RAM) so blanking is clean out of reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < RD_LAT; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign tap_out = dly_q[RD_LAT-1];
  end

  logic               valid_q, valid_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               fs_q, fs_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    valid_d = tap_out[0];
    hsync_d = tap_out[1] ? HSYNC_POL : !HSYNC_POL;
    vsync_d = tap_out[2] ? VSYNC_POL : !VSYNC_POL;
    fs_d    = tap_out[3];
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (tap_out[0]) begin
      r_d = rd_data[3*COLOR_W-1:2*COLOR_W];
      g_d = rd_data[2*COLOR_W-1:COLOR_W];
      b_d = rd_data[COLOR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      hsync_q <= !HSYNC_POL;
      vsync_q <= !VSYNC_POL;
      fs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout: four configurations checked every cycle against
// a position-based reference model, plus directed reset / enable / geometry checks.
module tb_vga_fb_scanout;

  typedef struct packed {
    logic        valid;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } out_t;

  typedef struct packed {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, sh;
  } cfg_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults. B: small timing. C: small timing, RD_LAT=3. D: 2x scaling, positive syncs.
  logic        rd_en_a, hsync_a, vsync_a, valid_a, fs_a;
  logic [18:0] rd_addr_a;
  logic [23:0] rd_data_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        rd_en_b, hsync_b, vsync_b, valid_b, fs_b;
  logic [7:0]  rd_addr_b;
  logic [23:0] rd_data_b;
  logic [7:0]  r_b, g_b, b_b;
  logic        rd_en_c, hsync_c, vsync_c, valid_c, fs_c;
  logic [7:0]  rd_addr_c;
  logic [23:0] rd_data_c;
  logic [7:0]  r_c, g_c, b_c;
  logic        rd_en_d, hsync_d, vsync_d, valid_d, fs_d;
  logic [5:0]  rd_addr_d;
  logic [23:0] rd_data_d;
  logic [7:0]  r_d, g_d, b_d;

  assign rd_data_a = 24'(rd_addr_a);
  assign rd_data_b = 24'(rd_addr_b);
  assign rd_data_d = 24'(rd_addr_d);

  logic [7:0] c_pipe [3];
  always @(posedge clk) begin
    c_pipe[2] <= c_pipe[1];
    c_pipe[1] <= c_pipe[0];
    c_pipe[0] <= rd_addr_c;
  end
  assign rd_data_c = 24'(c_pipe[2]);

  vga_fb_scanout u_a (
    .clk(clk), .reset(reset), .en(en), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .hsync(hsync_a), .vsync(vsync_a), .valid(valid_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .frame_start(fs_a));

  vga_fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RD_LAT(0), .ADDR_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .en(en), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .frame_start(fs_b));

  vga_fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RD_LAT(3), .ADDR_W(8)
  ) u_c (
    .clk(clk), .reset(reset), .en(en), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .hsync(hsync_c), .vsync(vsync_c), .valid(valid_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
    .frame_start(fs_c));

  vga_fb_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(1), .RD_LAT(0), .ADDR_W(6)
  ) u_d (
    .clk(clk), .reset(reset), .en(en), .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
    .hsync(hsync_d), .vsync(vsync_d), .valid(valid_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .frame_start(fs_d));

  function automatic cfg_t cfg_of(int i);
    case (i)
      0:       return '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0};
      1, 2:    return '{16, 2, 3, 4, 6, 1, 2, 1, 0, 0, 0};
      default: return '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1, 1};
    endcase
  endfunction

  function automatic int lat_of(int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic int htot(cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vfp + c.vs + c.vbp;
  endfunction

  function automatic bit in_act(cfg_t c, int p);
    int h, v;
    h = p % htot(c);
    v = (p / htot(c)) % vtot(c);
    return (h < c.ha) && (v < c.va);
  endfunction

  // Source pixel address from plain row/column arithmetic.
  function automatic int addr_of(cfg_t c, int p);
    int h, v;
    h = p % htot(c);
    v = (p / htot(c)) % vtot(c);
    return (v >> c.sh) * (c.ha >> c.sh) + (h >> c.sh);
  endfunction

  // Expected registered outputs for scan position p; p < 0 means idle (reset values).
  function automatic out_t model(cfg_t c, int p);
    out_t o;
    int h, v;
    o.valid = 1'b0;
    o.hs    = !c.hpol[0];
    o.vs    = !c.vpol[0];
    o.fs    = 1'b0;
    o.rgb   = '0;
    if (p >= 0) begin
      h = p % htot(c);
      v = (p / htot(c)) % vtot(c);
      o.valid = in_act(c, p);
      if (o.valid) o.rgb = 24'(addr_of(c, p));
      if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) o.hs = c.hpol[0];
      if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) o.vs = c.vpol[0];
      o.fs = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic out_t get_obs(int i);
    case (i)
      0:       return out_t'({valid_a, hsync_a, vsync_a, fs_a, r_a, g_a, b_a});
      1:       return out_t'({valid_b, hsync_b, vsync_b, fs_b, r_b, g_b, b_b});
      2:       return out_t'({valid_c, hsync_c, vsync_c, fs_c, r_c, g_c, b_c});
      default: return out_t'({valid_d, hsync_d, vsync_d, fs_d, r_d, g_d, b_d});
    endcase
  endfunction

  function automatic logic get_rden(int i);
    case (i)
      0:       return rd_en_a;
      1:       return rd_en_b;
      2:       return rd_en_c;
      default: return rd_en_d;
    endcase
  endfunction

  function automatic logic [63:0] get_addr(int i);
    case (i)
      0:       return 64'(rd_addr_a);
      1:       return 64'(rd_addr_b);
      2:       return 64'(rd_addr_c);
      default: return 64'(rd_addr_d);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference scan state: next position per instance and history of sampled positions.
  int pos  [4] = '{0, 0, 0, 0};
  int hist [4][5];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pos[i] = 0;
        for (int k = 0; k < 5; k++) hist[i][k] = -1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = en ? pos[i] : -1;
        pos[i] = en ? (pos[i] + 1) % (htot(cfg_of(i)) * vtot(cfg_of(i))) : 0;
      end
    end
  end

  always @(negedge clk) begin
    cfg_t c;
    logic exp_en;
    for (int i = 0; i < 4; i++) begin
      c = cfg_of(i);
      check($sformatf("out%0d", i), 64'(get_obs(i)), 64'(model(c, hist[i][lat_of(i)])));
      exp_en = !reset && en && in_act(c, pos[i]);
      check($sformatf("rd_en%0d", i), 64'(get_rden(i)), 64'(exp_en));
      if (exp_en) check($sformatf("rd_addr%0d", i), get_addr(i), 64'(addr_of(c, pos[i])));
    end
  end

  out_t sa [802];
  out_t sb [802];
  out_t sc [802];
  int   dq [$];

  initial begin
    int cnt, vfall, hfall, first;
    int fsq [$];
    int dur;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid_a), 64'(0));
    check("rst_hsync", 64'(hsync_a), 64'(1));
    check("rst_vsync", 64'(vsync_a), 64'(1));
    check("rst_fs", 64'(fs_a), 64'(0));
    check("rst_rgb", 64'({r_a, g_a, b_a}), 64'(0));
    check("rst_rd_en", 64'(rd_en_a), 64'(0));
    check("rst_rd_addr", 64'(rd_addr_a), 64'(0));
    check("rst_hsync_pos", 64'(hsync_d), 64'(0));

    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 802; k++) begin
      @(negedge clk);
      sa[k] = get_obs(0);
      sb[k] = get_obs(1);
      sc[k] = get_obs(2);
      if (rd_en_d) dq.push_back(int'(rd_addr_d));
    end

    check("pre_first_valid", 64'(sa[0].valid), 64'(0));
    check("first_valid", 64'(sa[1].valid), 64'(1));
    check("first_rgb", 64'(sa[1].rgb), 64'(0));
    check("first_fs", 64'(sa[1].fs), 64'(1));
    check("line0_last", 64'(sa[640].rgb), 64'(639));
    check("line1_first", 64'(sa[801].rgb), 64'(640));
    cnt = 0; vfall = -1; hfall = -1;
    for (int k = 1; k <= 800; k++) begin
      if (sa[k].valid) cnt++;
      if (!sa[k].valid && vfall < 0) vfall = k;
      if (!sa[k].hs && hfall < 0) hfall = k;
    end
    check("valid_per_line", 64'(cnt), 64'(640));
    cnt = 0;
    for (int k = 1; k <= 800; k++) if (!sa[k].hs) cnt++;
    check("hsync_low_count", 64'(cnt), 64'(96));
    check("hsync_after_valid", 64'(hfall - vfall), 64'(16));

    for (int k = 0; k < 802; k++) if (sb[k].fs) fsq.push_back(k);
    check("b_fs_count", 64'(fsq.size()), 64'(4));
    if (fsq.size() >= 3) begin
      check("b_fs_period0", 64'(fsq[1] - fsq[0]), 64'(250));
      check("b_fs_period1", 64'(fsq[2] - fsq[1]), 64'(250));
    end
    cnt = 0; first = -1;
    for (int k = 1; k <= 250; k++) begin
      if (!sb[k].vs) cnt++;
      if (!sb[k].vs && first < 0) first = k;
    end
    check("b_vsync_low", 64'(cnt), 64'(50));
    check("b_vsync_start", 64'(first), 64'(176));
    for (int k = 0; k < 799; k++) check($sformatf("lat3_shift%0d", k), 64'(sc[k+3]), 64'(sb[k]));

    check("d_reads", 64'(dq.size() >= 40), 64'(1));
    if (dq.size() >= 40) begin
      for (int k = 0; k < 40; k++) begin
        if (k < 32) check($sformatf("d_addr%0d", k), 64'(dq[k]), 64'(((k / 8) / 2) * 4 + (k % 8) / 2));
        else        check($sformatf("d_addr%0d", k), 64'(dq[k]), 64'((k - 32) / 2));
      end
    end

    // Asynchronous reset between edges.
    repeat ($urandom_range(50, 300)) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_valid", 64'(valid_a), 64'(0));
    check("async_hsync", 64'(hsync_a), 64'(1));
    check("async_vsync", 64'(vsync_a), 64'(1));
    check("async_rgb", 64'({r_a, g_a, b_a}), 64'(0));
    check("async_rd_en", 64'(rd_en_a), 64'(0));
    check("async_rd_addr", 64'(rd_addr_a), 64'(0));
    check("async_valid_c", 64'(valid_c), 64'(0));
    check("async_hsync_d", 64'(hsync_d), 64'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rel_rd_addr", 64'(rd_addr_a), 64'(0));
    check("rel_rd_en", 64'(rd_en_a), 64'(1));
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) check("rel_fs_a", 64'(fs_a), 64'(1));
      check($sformatf("rel_fs_c%0d", e), 64'(fs_c), 64'(e == 4));
    end

    // Enable drops of random length at random points.
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(30, 400)) @(posedge clk);
      #2 en = 1'b0;
      #1;
      check("en_rd_en_a", 64'(rd_en_a), 64'(0));
      check("en_rd_en_c", 64'(rd_en_c), 64'(0));
      check("en_rd_en_d", 64'(rd_en_d), 64'(0));
      dur = $urandom_range(5, 12);
      for (int e = 1; e <= dur; e++) begin
        @(posedge clk);
        #1;
        if (e == 1) begin
          check("en_valid_a", 64'(valid_a), 64'(0));
          check("en_rd_addr_a", 64'(rd_addr_a), 64'(0));
        end
        if (e >= 4) begin
          check("en_valid_c", 64'(valid_c), 64'(0));
          check("en_hsync_c", 64'(hsync_c), 64'(1));
        end
      end
      #1 en = 1'b1;
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk);
        #1;
        if (e == 1) check("en_fs_a", 64'(fs_a), 64'(1));
        check($sformatf("en_fs_c%0d", e), 64'(fs_c), 64'(e == 4));
      end
    end

    repeat (600) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
